// File: rtl/alu_sched_pkg.sv
// Shared constants and types for the two-requester ALU scheduler.
`timescale 1ns/1ps
package alu_sched_pkg;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  // Opcodes with the top bit set are reserved and never reach the ALU.
  function automatic logic is_reserved(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/alu_rr_arb.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the one not granted last.
`timescale 1ns/1ps
module alu_rr_arb (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_grant_i,
  output logic grant_valid_o,
  output logic grant_idx_o
);

  assign grant_valid_o = valid0_i | valid1_i;
  assign grant_idx_o   = (valid0_i && valid1_i) ? ~last_grant_i : valid1_i;

endmodule

// File: rtl/alu_scheduler.sv
// Shares one ALU between two requesters; one operation in flight at a time.
// Optional macro ALU_SCHED_ZERO_FLAG_EN adds rsp0_zero/rsp1_zero outputs.
`timescale 1ns/1ps
module alu_scheduler
  import alu_sched_pkg::*;
#(
  parameter int ADD_LAT   = 2,
  parameter int LOGIC_LAT = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [2:0] req0_op,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic [7:0] rsp0_result,
  output logic       rsp0_err,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [2:0] req1_op,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [7:0] rsp1_result,
  output logic       rsp1_err,
`ifdef ALU_SCHED_ZERO_FLAG_EN
  output logic       rsp0_zero,
  output logic       rsp1_zero,
`endif
  output logic [7:0] alu_data1,
  output logic [7:0] alu_data2,
  output logic [2:0] alu_select,
  input  logic [7:0] alu_result
);

  localparam logic [CNT_W-1:0] ADD_CNT   = CNT_W'(ADD_LAT - 1);
  localparam logic [CNT_W-1:0] LOGIC_CNT = CNT_W'(LOGIC_LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gidx_q, gidx_d;
  logic             last_grant_q, last_grant_d;
  logic [2:0]       op_q, op_d;
  logic [7:0]       a_q, a_d;
  logic [7:0]       b_q, b_d;
  logic [7:0]       result_q, result_d;
  logic             err_q, err_d;
`ifdef ALU_SCHED_ZERO_FLAG_EN
  logic             zero_q, zero_d;
`endif

  logic       grant_valid;
  logic       grant_idx;
  logic [2:0] sel_op;
  logic [7:0] sel_a;
  logic [7:0] sel_b;
  logic       sel_rsp_ready;

  alu_rr_arb u_arb (
    .valid0_i      (req0_valid),
    .valid1_i      (req1_valid),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );

  assign sel_op        = grant_idx ? req1_op : req0_op;
  assign sel_a         = grant_idx ? req1_a  : req0_a;
  assign sel_b         = grant_idx ? req1_b  : req0_b;
  assign sel_rsp_ready = gidx_q ? rsp1_ready : rsp0_ready;

  assign req0_ready  = (state_q == IDLE) && grant_valid && !grant_idx;
  assign req1_ready  = (state_q == IDLE) && grant_valid &&  grant_idx;
  assign rsp0_valid  = (state_q == RESP) && !gidx_q;
  assign rsp1_valid  = (state_q == RESP) &&  gidx_q;
  assign rsp0_result = result_q;
  assign rsp1_result = result_q;
  assign rsp0_err    = err_q;
  assign rsp1_err    = err_q;
`ifdef ALU_SCHED_ZERO_FLAG_EN
  assign rsp0_zero   = rsp0_valid & zero_q;
  assign rsp1_zero   = rsp1_valid & zero_q;
`endif

  // The ALU drive registers only change on a legal accept, so they persist outside EXEC.
  assign alu_select = op_q;
  assign alu_data1  = a_q;
  assign alu_data2  = b_q;

  // Next-state and datapath load decisions.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gidx_d       = gidx_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
    err_d        = err_q;
`ifdef ALU_SCHED_ZERO_FLAG_EN
    zero_d       = zero_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          gidx_d = grant_idx;
          if (!is_reserved(sel_op)) begin
            op_d    = sel_op;
            a_d     = sel_a;
            b_d     = sel_b;
            cnt_d   = (sel_op == ALU_ADD) ? ADD_CNT : LOGIC_CNT;
            state_d = EXEC;
          end else begin
            result_d = 8'h00;
            err_d    = 1'b1;
`ifdef ALU_SCHED_ZERO_FLAG_EN
            zero_d   = 1'b0;
`endif
            state_d  = RESP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          result_d = alu_result;
          err_d    = 1'b0;
`ifdef ALU_SCHED_ZERO_FLAG_EN
          zero_d   = (alu_result == 8'h00);
`endif
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      RESP: begin
        if (sel_rsp_ready) begin
          last_grant_d = gidx_q;
          state_d      = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; last_grant resets to 1 so requester 0 wins first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      gidx_q       <= 1'b0;
      last_grant_q <= 1'b1;
      op_q         <= 3'b000;
      a_q          <= 8'h00;
      b_q          <= 8'h00;
      result_q     <= 8'h00;
      err_q        <= 1'b0;
`ifdef ALU_SCHED_ZERO_FLAG_EN
      zero_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gidx_q       <= gidx_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
      err_q        <= err_d;
`ifdef ALU_SCHED_ZERO_FLAG_EN
      zero_q       <= zero_d;
`endif
    end
  end

endmodule
